fetch_seq_ctrl: RTL and testbench
=================================

# fetch_seq_ctrl

Sequencer for the 32-bit fetch path of the frontend. It issues aligned fetch requests to the instruction cache and forwards each response to the instruction re-aligner (data, full fetch address, flush). Fetch is throttled by a credit count against the downstream instruction queue. It also handles redirects, in-flight kills, fetch faults and halt requests, and keeps an unaligned 32-bit instruction from being split across a halt.

## Interface
Parameters:
- VLEN, 32, virtual address width.
- FETCH_WIDTH, 32, fetch block width in bits; only 32 is supported; FETCH_BYTES = FETCH_WIDTH/8.
- INSTR_PER_FETCH, 2, maximum instructions the re-aligner emits per fetch; this many credits are reserved per request.
- QUEUE_DEPTH, 8, instruction queue entries; CW = $clog2(QUEUE_DEPTH+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- boot_addr_i  in  VLEN  first fetch PC, sampled in BOOT.
- redirect_i  in  1  branch/exception/flush redirect pulse.
- redirect_addr_i  in  VLEN  new PC; bit 1 may be set.
- halt_i  in  1  level; stop issuing new fetches.
- halted_o  out  1  high in HALTED.
- req_o  out  1  cache request valid.
- req_addr_o  out  VLEN  {pc[VLEN-1:2],2'b00}.
- req_ready_i  in  1  cache grant; handshake = req_o & req_ready_i.
- rsp_valid_i  in  1  cache response valid, one per granted request.
- rsp_data_i  in  FETCH_WIDTH  response data.
- rsp_ex_i  in  1  fetch fault with response.
- kill_o  out  1  pulse; abort the outstanding cache request.
- realign_valid_o  out  1  to the re-aligner valid_i.
- realign_addr_o  out  VLEN  to the re-aligner address_i; the full PC of the request.
- realign_data_o  out  FETCH_WIDTH  to the re-aligner data_i.
- realign_flush_o  out  1  to the re-aligner flush_i.
- serving_unaligned_i  in  1  from the re-aligner serving_unaligned_o.
- fetch_ex_o  out  1  qualifies realign_valid_o as faulting.
- credit_return_i  in  CW  queue slots freed this cycle (pops plus unused reserved slots).

## Operation
- State: pc (VLEN), req_pc (VLEN, the PC of the outstanding request), credits (CW), FSM.
- FSM states: BOOT, REQ, WAIT, KILL, HALTED, FAULT.
- BOOT (reset state): pc <= boot_addr_i, then go to REQ next cycle. No outputs are asserted in BOOT.
- REQ: req_o = !redirect_i & !halt_gate & (credits >= INSTR_PER_FETCH).
  - halt_gate = halt_i & !serving_unaligned_i.
  - On handshake: req_pc <= pc; pc <= {pc[VLEN-1:2],2'b00} + FETCH_BYTES; credits -= INSTR_PER_FETCH; go to WAIT.
  - If halt_gate is set, go to HALTED.
- WAIT: on rsp_valid_i, realign_valid_o = 1 in the same cycle, with realign_addr_o = req_pc, realign_data_o = rsp_data_i, fetch_ex_o = rsp_ex_i.
  - Next state is FAULT if rsp_ex_i, otherwise REQ.
- KILL: drop the next rsp_valid_i (no realign_valid_o), return INSTR_PER_FETCH credits, go to REQ.
- HALTED: halted_o = 1. Leave to REQ when halt_i deasserts.
- FAULT: no requests are issued until redirect_i.
- redirect_i, from any state except BOOT, has priority over everything else in the cycle:
  - pc <= redirect_addr_i; realign_flush_o = 1 in the same cycle; credits <= QUEUE_DEPTH (the queue is flushed by the same event); credit_return_i is ignored.
  - From WAIT without rsp_valid_i that cycle: kill_o = 1, go to KILL.
  - From WAIT with rsp_valid_i that cycle: the response is dropped (realign_valid_o = 0), go to REQ.
  - From KILL: stay in KILL with the new pc.
  - From any other state: go to REQ.
- Credit arithmetic:
  - credits_next = credits − (handshake ? INSTR_PER_FETCH : 0) + credit_return_i + (kill drop ? INSTR_PER_FETCH : 0).
  - Exceeding QUEUE_DEPTH is an assertion failure, and the value saturates at QUEUE_DEPTH.

## Timing
- Reset values: all outputs 0, credits = QUEUE_DEPTH, state BOOT. The first req_o can assert 2 cycles after reset release.
- Response forwarding is combinational: zero latency from rsp_valid_i to realign_valid_o. The re-aligner adds its own register stage.
- There is at most one outstanding request. The next req_o is earliest the cycle after the response, giving 1 fetch per 2 cycles at best.
- req_o must stay asserted with a stable req_addr_o until granted, unless redirect_i or halt_gate drops it.
- kill_o is a single-cycle pulse.
- realign_flush_o asserts exactly in the redirect_i cycle.
- serving_unaligned_i is sampled in REQ. It reflects the response accepted in the previous WAIT cycle.

## Test plan
- Sequential fetch: boot 0x80000000, grant immediately, response 1 cycle later → req_addr_o 0x80000000, 0x80000004, 0x80000008; realign_addr_o matches each; credits drop by 2 and return via credit_return_i = 2.
- Credit stall: QUEUE_DEPTH = 8, credit_return_i = 0 → exactly 4 handshakes, then req_o stays 0. Pulse credit_return_i = 2 → one more request.
- Redirect in WAIT: redirect to 0x80000102 before the response → kill_o and realign_flush_o pulse, the next response is dropped, then req_addr_o = 0x80000100 and realign_addr_o = 0x80000102.
- Redirect coincident with rsp_valid_i → realign_valid_o = 0, no kill_o, next req_addr_o = redirect target aligned.
- Halt with serving_unaligned_i = 1 → one further fetch is issued, then HALTED. Deassert halt_i → fetch resumes at the next sequential address.
- Fault: rsp_ex_i = 1 → realign_valid_o and fetch_ex_o are 1, req_o stays 0 in FAULT. redirect_i → fetch restarts at redirect_addr_i.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: sequencer for the 32-bit instruction fetch path.
// Issues aligned fetch requests to the I-cache (one outstanding at a time),
// forwards each response combinationally to the re-aligner, throttles on
// instruction-queue credits, and handles redirects, kills, faults and halts.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   boot_addr_i              first fetch PC, sampled in BOOT
//   redirect_i/_addr_i       redirect pulse and new PC (bit 1 may be set)
//   halt_i / halted_o        halt request level / halted status
//   req_o/req_addr_o/req_ready_i   cache request handshake
//   rsp_valid_i/rsp_data_i/rsp_ex_i cache response
//   kill_o                   abort the outstanding cache request
//   realign_*_o              re-aligner valid/addr/data/flush
//   serving_unaligned_i      re-aligner holds the first half of an instruction
//   fetch_ex_o               marks realign_valid_o as faulting
//   credit_return_i          queue slots freed this cycle
//
// state  | meaning
// BOOT   | load pc from boot_addr_i
// REQ    | request the block at pc when credits allow
// WAIT   | request granted, forward the response
// KILL   | request aborted by redirect, drop its response
// HALTED | halt accepted, no fetch until halt_i drops
// FAULT  | fetch fault forwarded, idle until redirect
module fetch_seq_ctrl #(
  parameter int VLEN            = 32,
  parameter int FETCH_WIDTH     = 32,
  parameter int INSTR_PER_FETCH = 2,
  parameter int QUEUE_DEPTH     = 8,
  localparam int CW             = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [VLEN-1:0]        boot_addr_i,
  input  logic                   redirect_i,
  input  logic [VLEN-1:0]        redirect_addr_i,
  input  logic                   halt_i,
  output logic                   halted_o,
  output logic                   req_o,
  output logic [VLEN-1:0]        req_addr_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic [FETCH_WIDTH-1:0] rsp_data_i,
  input  logic                   rsp_ex_i,
  output logic                   kill_o,
  output logic                   realign_valid_o,
  output logic [VLEN-1:0]        realign_addr_o,
  output logic [FETCH_WIDTH-1:0] realign_data_o,
  output logic                   realign_flush_o,
  input  logic                   serving_unaligned_i,
  output logic                   fetch_ex_o,
  input  logic [CW-1:0]          credit_return_i
);

  localparam int          FETCH_BYTES = FETCH_WIDTH / 8;
  localparam logic [CW:0] IPF_W       = (CW+1)'(INSTR_PER_FETCH);
  localparam logic [CW:0] QD_W        = (CW+1)'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    ST_BOOT, ST_REQ, ST_WAIT, ST_KILL, ST_HALTED, ST_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [VLEN-1:0] pc_q, req_pc_q, pc_aligned;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW:0]     ext_sum, credit_sum;
  logic            halt_gate, handshake, kill_drop, redirect_active;

  // A halt never lands between the two halves of an unaligned instruction.
  assign halt_gate       = halt_i & !serving_unaligned_i;
  assign handshake       = req_o & req_ready_i;
  assign redirect_active = redirect_i & (state_q != ST_BOOT);
  assign kill_drop       = (state_q == ST_KILL) & rsp_valid_i & !redirect_i;
  assign pc_aligned      = {pc_q[VLEN-1:2], 2'b00};

  // The kill refund always follows a redirect that already refilled the
  // counter, so it is absorbed by saturation; only the downstream return
  // path is held to the queue depth.
  assign ext_sum    = {1'b0, credits_q} - (handshake ? IPF_W : '0) + {1'b0, credit_return_i};
  assign credit_sum = ext_sum + (kill_drop ? IPF_W : '0);

  always_comb begin
    credits_d = credits_q;
    if (redirect_active)         credits_d = QD_W[CW-1:0];
    else if (credit_sum > QD_W)  credits_d = QD_W[CW-1:0];
    else                         credits_d = credit_sum[CW-1:0];
  end

  credit_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    redirect_active || (ext_sum <= QD_W));

  // State register and datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_BOOT;
      pc_q      <= '0;
      req_pc_q  <= '0;
      credits_q <= QD_W[CW-1:0];
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      if (state_q == ST_BOOT) begin
        pc_q <= boot_addr_i;
      end else if (redirect_i) begin
        pc_q <= redirect_addr_i;
      end else if (handshake) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_aligned + VLEN'(FETCH_BYTES);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_REQ;
      ST_REQ: begin
        if (redirect_i)     state_d = ST_REQ;
        else if (handshake) state_d = ST_WAIT;
        else if (halt_gate) state_d = ST_HALTED;
      end
      ST_WAIT: begin
        if (redirect_i)       state_d = rsp_valid_i ? ST_REQ : ST_KILL;
        else if (rsp_valid_i) state_d = rsp_ex_i ? ST_FAULT : ST_REQ;
      end
      // A redirect re-arms KILL unless the stale response drains that cycle.
      ST_KILL:   if (rsp_valid_i) state_d = ST_REQ;
      ST_HALTED: if (redirect_i || !halt_i) state_d = ST_REQ;
      ST_FAULT:  if (redirect_i) state_d = ST_REQ;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    req_o           = 1'b0;
    kill_o          = 1'b0;
    halted_o        = 1'b0;
    realign_valid_o = 1'b0;
    fetch_ex_o      = 1'b0;
    case (state_q)
      ST_REQ:    req_o = !redirect_i & !halt_gate & ({1'b0, credits_q} >= IPF_W);
      ST_WAIT: begin
        realign_valid_o = rsp_valid_i & !redirect_i;
        fetch_ex_o      = rsp_valid_i & !redirect_i & rsp_ex_i;
        kill_o          = redirect_i & !rsp_valid_i;
      end
      ST_HALTED: halted_o = 1'b1;
      default: ;
    endcase
    realign_flush_o = redirect_active;
  end

  assign req_addr_o     = pc_aligned;
  assign realign_addr_o = req_pc_q;
  assign realign_data_o = rsp_data_i;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;
  localparam int VLEN = 32;
  localparam int FW   = 32;
  localparam int CW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [VLEN-1:0] boot_addr_i;
  logic            redirect_i;
  logic [VLEN-1:0] redirect_addr_i;
  logic            halt_i;
  logic            halted_o;
  logic            req_o;
  logic [VLEN-1:0] req_addr_o;
  logic            req_ready_i;
  logic            rsp_valid_i;
  logic [FW-1:0]   rsp_data_i;
  logic            rsp_ex_i;
  logic            kill_o;
  logic            realign_valid_o;
  logic [VLEN-1:0] realign_addr_o;
  logic [FW-1:0]   realign_data_o;
  logic            realign_flush_o;
  logic            serving_unaligned_i;
  logic            fetch_ex_o;
  logic [CW-1:0]   credit_return_i;

  int n_vec = 0;
  int n_err = 0;

  fetch_seq_ctrl dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .boot_addr_i        (boot_addr_i),
    .redirect_i         (redirect_i),
    .redirect_addr_i    (redirect_addr_i),
    .halt_i             (halt_i),
    .halted_o           (halted_o),
    .req_o              (req_o),
    .req_addr_o         (req_addr_o),
    .req_ready_i        (req_ready_i),
    .rsp_valid_i        (rsp_valid_i),
    .rsp_data_i         (rsp_data_i),
    .rsp_ex_i           (rsp_ex_i),
    .kill_o             (kill_o),
    .realign_valid_o    (realign_valid_o),
    .realign_addr_o     (realign_addr_o),
    .realign_data_o     (realign_data_o),
    .realign_flush_o    (realign_flush_o),
    .serving_unaligned_i(serving_unaligned_i),
    .fetch_ex_o         (fetch_ex_o),
    .credit_return_i    (credit_return_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full fetch: grant in REQ, respond in the following WAIT cycle.
  task automatic fetch_one(input logic [31:0] req_exp, input logic [31:0] rl_exp,
                           input logic [31:0] data, input logic [CW-1:0] ret,
                           input logic ex);
    req_ready_i = 1'b1;
    #1;
    check("req_o", 64'(req_o), 64'd1);
    check("req_addr", 64'(req_addr_o), 64'(req_exp));
    tick();
    req_ready_i     = 1'b0;
    rsp_valid_i     = 1'b1;
    rsp_data_i      = data;
    rsp_ex_i        = ex;
    credit_return_i = ret;
    #1;
    check("rl_valid", 64'(realign_valid_o), 64'd1);
    check("rl_addr", 64'(realign_addr_o), 64'(rl_exp));
    check("rl_data", 64'(realign_data_o), 64'(data));
    check("fetch_ex", 64'(fetch_ex_o), 64'(ex));
    check("req_in_wait", 64'(req_o), 64'd0);
    tick();
    rsp_valid_i     = 1'b0;
    rsp_ex_i        = 1'b0;
    credit_return_i = '0;
  endtask

  initial begin
    rst_ni              = 1'b0;
    boot_addr_i         = 32'h8000_0000;
    redirect_i          = 1'b0;
    redirect_addr_i     = '0;
    halt_i              = 1'b0;
    req_ready_i         = 1'b0;
    rsp_valid_i         = 1'b0;
    rsp_data_i          = '0;
    rsp_ex_i            = 1'b0;
    serving_unaligned_i = 1'b0;
    credit_return_i     = '0;
    repeat (2) tick();

    // reset state
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);
    check("rst_kill", 64'(kill_o), 64'd0);
    check("rst_rl_valid", 64'(realign_valid_o), 64'd0);
    check("rst_flush", 64'(realign_flush_o), 64'd0);
    check("rst_req_addr", 64'(req_addr_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    check("boot_req", 64'(req_o), 64'd0);
    tick();
    check("first_req", 64'(req_o), 64'd1);

    // sequential fetch with immediate credit return
    for (int i = 0; i < 3; i++)
      fetch_one(32'h8000_0000 + 32'(4*i), 32'h8000_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'd2, 1'b0);

    // credit stall: four requests drain 8 credits
    for (int i = 0; i < 4; i++)
      fetch_one(32'h8000_000C + 32'(4*i), 32'h8000_000C + 32'(4*i), 32'hB000_0000 + 32'(i), 4'd0, 1'b0);
    req_ready_i = 1'b1;
    #1;
    check("stall_req0", 64'(req_o), 64'd0);
    tick();
    check("stall_req1", 64'(req_o), 64'd0);
    credit_return_i = 4'd2;
    tick();
    credit_return_i = '0;
    req_ready_i     = 1'b0;
    #1;
    check("unstall_req", 64'(req_o), 64'd1);
    check("unstall_addr", 64'(req_addr_o), 64'h8000_001C);
    fetch_one(32'h8000_001C, 32'h8000_001C, 32'hC0DE_0001, 4'd8, 1'b0);

    // redirect while waiting for the response
    req_ready_i = 1'b1;
    #1;
    check("kill_req_addr", 64'(req_addr_o), 64'h8000_0020);
    tick();
    req_ready_i     = 1'b0;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h8000_0102;
    #1;
    check("kill_pulse", 64'(kill_o), 64'd1);
    check("kill_flush", 64'(realign_flush_o), 64'd1);
    check("kill_rl_valid", 64'(realign_valid_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    check("kill_single", 64'(kill_o), 64'd0);
    check("flush_single", 64'(realign_flush_o), 64'd0);
    check("kill_no_req", 64'(req_o), 64'd0);
    tick();
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'hDEAD_BEEF;
    #1;
    check("kill_drop", 64'(realign_valid_o), 64'd0);
    tick();
    rsp_valid_i = 1'b0;
    fetch_one(32'h8000_0100, 32'h8000_0102, 32'h1111_2222, 4'd2, 1'b0);

    // redirect coincident with the response
    req_ready_i = 1'b1;
    #1;
    check("co_req_addr", 64'(req_addr_o), 64'h8000_0104);
    tick();
    req_ready_i     = 1'b0;
    rsp_valid_i     = 1'b1;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h8000_0206;
    #1;
    check("co_rl_valid", 64'(realign_valid_o), 64'd0);
    check("co_kill", 64'(kill_o), 64'd0);
    check("co_flush", 64'(realign_flush_o), 64'd1);
    tick();
    rsp_valid_i = 1'b0;
    redirect_i  = 1'b0;
    fetch_one(32'h8000_0204, 32'h8000_0206, 32'h3333_4444, 4'd2, 1'b0);

    // halt held off by an unaligned instruction in the re-aligner
    halt_i              = 1'b1;
    serving_unaligned_i = 1'b1;
    fetch_one(32'h8000_0208, 32'h8000_0208, 32'h5555_6666, 4'd2, 1'b0);
    serving_unaligned_i = 1'b0;
    #1;
    check("halt_no_req", 64'(req_o), 64'd0);
    tick();
    check("halted", 64'(halted_o), 64'd1);
    check("halted_no_req", 64'(req_o), 64'd0);
    tick();
    halt_i = 1'b0;
    #1;
    check("halted_hold", 64'(halted_o), 64'd1);
    tick();
    check("resume_halted", 64'(halted_o), 64'd0);
    fetch_one(32'h8000_020C, 32'h8000_020C, 32'h7777_8888, 4'd2, 1'b0);

    // fetch fault, idle until redirect
    fetch_one(32'h8000_0210, 32'h8000_0210, 32'h9999_AAAA, 4'd2, 1'b1);
    req_ready_i = 1'b1;
    #1;
    check("fault_no_req0", 64'(req_o), 64'd0);
    tick();
    check("fault_no_req1", 64'(req_o), 64'd0);
    req_ready_i     = 1'b0;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h8000_0300;
    #1;
    check("fault_flush", 64'(realign_flush_o), 64'd1);
    check("fault_redir_no_req", 64'(req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    fetch_one(32'h8000_0300, 32'h8000_0300, 32'hBBBB_CCCC, 4'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100us");
    $fatal(1);
  end
endmodule
